// File: rtl/aes_key_expansion_dec_if.sv
// Request/response bundle between the AES-128 key schedule and its consumer.
interface aes_key_expansion_dec_if;
   logic         start;
   logic [127:0] key;
   logic [3:0]   round_sel;
   logic [127:0] round_key;
   logic         busy;
   logic         ready;

   modport master (
      output start, key, round_sel,
      input  round_key, busy, ready
   );

   modport slave (
      input  start, key, round_sel,
      output round_key, busy, ready
   );
endinterface

// File: rtl/aes_key_expansion_dec.sv
// AES-128 key schedule: expands a key into NR+1 stored round keys, one per cycle, and serves them.
// Optional KEYEXP_REVERSE_EN inverts the read index so round_sel=0 returns the last round key.
module aes_key_expansion_dec #(
   parameter int unsigned NR = 10
) (
   input logic                    clock,
   input logic                    reset,
   aes_key_expansion_dec_if.slave bus
);

   localparam logic [3:0] NrIdx = 4'(NR);

   typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

   state_e       state_q, state_d;
   logic         load_en, step_en, busy, ready;
   logic [127:0] rk_q [0:NR];
   logic [127:0] w_q, w_next, round_key_q;
   logic [31:0]  t, nw0, nw1, nw2, nw3;
   logic [7:0]   rcon_q, rcon_next;
   logic [3:0]   cnt_q, rd_idx;
   logic         rd_valid;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box built algebraically: x^254 is the GF(2^8) inverse (0 maps to 0), then affine.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StReady: if (bus.start) state_d = StExpand;
         StExpand:        if (cnt_q == NrIdx) state_d = StReady;
         default:         state_d = StIdle;
      endcase
   end

   // Moore outputs and datapath enables; start is ignored while expanding
   always_comb begin
      busy    = 1'b0;
      ready   = 1'b0;
      load_en = 1'b0;
      step_en = 1'b0;
      unique case (state_q)
         StIdle:   load_en = bus.start;
         StExpand: begin
            busy    = 1'b1;
            step_en = 1'b1;
         end
         StReady:  begin
            ready   = 1'b1;
            load_en = bus.start;
         end
         default:  ;
      endcase
   end

   // w_q holds w0..w3 with w0 in the most significant word
   assign t         = sub_word({w_q[23:0], w_q[31:24]}) ^ {rcon_q, 24'h0};
   assign nw0       = w_q[127:96] ^ t;
   assign nw1       = w_q[95:64]  ^ nw0;
   assign nw2       = w_q[63:32]  ^ nw1;
   assign nw3       = w_q[31:0]   ^ nw2;
   assign w_next    = {nw0, nw1, nw2, nw3};
   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

`ifdef KEYEXP_REVERSE_EN
   assign rd_idx = NrIdx - bus.round_sel;
`else
   assign rd_idx = bus.round_sel;
`endif
   assign rd_valid = (bus.round_sel <= NrIdx);

   always_ff @(posedge clock) begin
      if (!reset) begin
         rk_q        <= '{default: '0};
         w_q         <= '0;
         rcon_q      <= 8'h01;
         cnt_q       <= 4'd0;
         round_key_q <= '0;
      end else begin
         if (load_en) begin
            rk_q[0] <= bus.key;
            w_q     <= bus.key;
            rcon_q  <= 8'h01;
            cnt_q   <= 4'd1;
         end else if (step_en) begin
            rk_q[cnt_q] <= w_next;
            w_q         <= w_next;
            rcon_q      <= rcon_next;
            cnt_q       <= cnt_q + 4'd1;
         end
         round_key_q <= rd_valid ? rk_q[rd_idx] : '0;
      end
   end

   assign bus.busy      = busy;
   assign bus.ready     = ready;
   assign bus.round_key = round_key_q;

endmodule

// File: tb/tb_aes_key_expansion_dec.sv
// Randomized self-checking bench for aes_key_expansion_dec against a word-array key schedule model.
module tb_aes_key_expansion_dec;

   localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] Rk1Fips = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RkAFips = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KeyC1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] RkAC1   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   aes_key_expansion_dec_if bus ();

   aes_key_expansion_dec #(.NR(10)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] sbox_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      end
      return p;
   endfunction

   // S-box from a brute-force inverse search
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv;
         for (int r = 1; r <= 4; r++) s ^= 8'((inv << r) | (inv >> (8 - r)));
         sbox_tab[x] = s ^ 8'h63;
      end
   endtask

   // Textbook 44-word expansion, returns round key r
   function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                   sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [3:0] sel_for(input int r);
`ifdef KEYEXP_REVERSE_EN
      return 4'(10 - r);
`else
      return 4'(r);
`endif
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: full schedule computed at start, revealed one round key per cycle
   logic [127:0] m_rk    [0:10];
   logic [127:0] m_sched [0:10];
   logic [127:0] m_out;
   logic         m_busy, m_ready;
   bit           m_valid = 0;
   int           m_step;

   always @(posedge clock) begin
      int sel;
      logic [127:0] rd;
      sel = int'(bus.round_sel);
      if (sel > 10) rd = '0;
`ifdef KEYEXP_REVERSE_EN
      else rd = m_rk[10 - sel];
`else
      else rd = m_rk[sel];
`endif
      if (!reset) begin
         for (int i = 0; i <= 10; i++) m_rk[i] = '0;
         m_out   = '0;
         m_busy  = 1'b0;
         m_ready = 1'b0;
         m_step  = 0;
         m_valid = 1;
      end else begin
         m_out = rd;
         if (m_busy) begin
            m_rk[m_step] = m_sched[m_step];
            if (m_step == 10) begin
               m_busy  = 1'b0;
               m_ready = 1'b1;
            end
            m_step++;
         end else if (bus.start) begin
            for (int i = 0; i <= 10; i++) m_sched[i] = model_rk(bus.key, i);
            m_rk[0] = bus.key;
            m_step  = 1;
            m_busy  = 1'b1;
            m_ready = 1'b0;
         end
      end
   end

   always @(posedge clock) begin
      #1;
      if (m_valid) begin
         check("busy", 128'(bus.busy), 128'(m_busy));
         check("ready", 128'(bus.ready), 128'(m_ready));
         check("round_key", bus.round_key, m_out);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic pulse_start(input logic [127:0] k);
      bus.key   = k;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.ready && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic read_rk(input int r, input logic [127:0] exp, input string name);
      bus.round_sel = sel_for(r);
      tick();
      check(name, bus.round_key, exp);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int n;
      bus.start     = 1'b0;
      bus.key       = '0;
      bus.round_sel = 4'd5;
      build_sbox();
      check("model_fips_rk1", model_rk(KeyFips, 1), Rk1Fips);
      check("model_fips_rk10", model_rk(KeyFips, 10), RkAFips);
      check("model_c1_rk10", model_rk(KeyC1, 10), RkAC1);

      // Reset state
      repeat (2) tick();
      check("rst_busy", 128'(bus.busy), 128'b0);
      check("rst_ready", 128'(bus.ready), 128'b0);
      check("rst_round_key", bus.round_key, 128'h0);
      reset = 1'b1;
      tick();
      check("rst_sel5", bus.round_key, 128'h0);

      // FIPS-197 key
      pulse_start(KeyFips);
      check("fips_busy", 128'(bus.busy), 128'b1);
      wait_ready(n);
      check("fips_latency", 128'(n), 128'd10);
      read_rk(0, KeyFips, "fips_rk0");
      read_rk(1, Rk1Fips, "fips_rk1");
      read_rk(10, RkAFips, "fips_rk10");

      // Second start during expansion is ignored
      pulse_start(KeyFips);
      n = 0;
      while (!bus.ready && n < 30) begin
         bus.start = (n == 3);
         if (n == 3) bus.key = rnd128();
         tick();
         n++;
      end
      bus.start = 1'b0;
      check("ignore_latency", 128'(n), 128'd10);
      read_rk(10, RkAFips, "ignore_rk10");

      // Reset mid-expansion
      pulse_start(rnd128());
      repeat (4) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_busy", 128'(bus.busy), 128'b0);
      check("abort_ready", 128'(bus.ready), 128'b0);
      read_rk(0, 128'h0, "abort_rk0_cleared");
      pulse_start(rnd128());
      wait_ready(n);
      check("restart_latency", 128'(n), 128'd10);

      // Re-key from READY
      pulse_start(KeyC1);
      check("rekey_ready_drop", 128'(bus.ready), 128'b0);
      wait_ready(n);
      check("rekey_latency", 128'(n), 128'd10);
      read_rk(10, RkAC1, "rekey_rk10");
      bus.round_sel = 4'd11;
      tick();
      check("sel11_zero", bus.round_key, 128'h0);
      bus.round_sel = 4'd15;
      tick();
      check("sel15_zero", bus.round_key, 128'h0);

      // Random keys, reads, stray starts and occasional resets
      for (int it = 0; it < 25; it++) begin
         pulse_start(rnd128());
         for (int c = 0; c < 14; c++) begin
            bus.round_sel = 4'($urandom_range(0, 15));
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.key       = rnd128();
            reset         = ($urandom_range(0, 59) != 0);
            tick();
         end
         bus.start = 1'b0;
         reset     = 1'b1;
      end
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_key_expansion_dec.md
# aes_key_expansion_dec

AES-128 key-schedule stage sitting directly upstream of the decryption datapath. It expands the 128-bit cipher key into the 11 round keys once per key load and stores them. It then serves any round key on request, so the inverse cipher can walk rounds 10 down to 0 without recomputing the schedule.

## Interface
- NR, default 10: number of AES rounds. Only 10 (AES-128) is supported; storage depth is NR+1.
- clock  in  1: single clock; all state updates on rising edge.
- reset  in  1: synchronous, active-low; sampled on the rising edge of clock.
- start  in  1: one-cycle pulse; latch `key` and begin expansion.
- key  in  128: cipher key, MSB = byte 0.
- round_sel  in  4: round key index to read, 0..NR.
- round_key  out  128: registered round key selected by round_sel.
- busy  out  1: high while expansion is in progress.
- ready  out  1: high when all NR+1 round keys are valid.

## Operation
- States:
  - IDLE: after reset.
  - EXPAND: generating keys.
  - READY: schedule valid.
- IDLE/READY + start=1:
  - Store key as rk[0] and load the working words w0..w3 from key.
  - Set rcon=8'h01, round counter i=1, busy=1, ready=0.
  - Go to EXPAND.
- EXPAND, one round key per cycle:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Write {w0',w1',w2',w3'} to rk[i] and to the working words.
  - Update rcon = xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), within 8 bits.
  - Increment i.
- Leaving EXPAND: when rk[NR] is written, go to READY with busy=0, ready=1.
- SubWord uses the codebase's existing forward S-box, four instances on the 32-bit word.
- start during EXPAND is ignored. The in-flight expansion completes with the original key.
- start in READY: re-expansion. ready drops the cycle after start is sampled; rk contents are overwritten progressively.
- Read port:
  - round_key <= rk[round_sel] every cycle, regardless of state.
  - round_sel > NR yields 128'h0.
  - Values read while ready=0 are undefined to the consumer, but deterministic: the current storage contents.
- Consumer rule: decryption must not assert its own start until ready=1.

## Timing
- Reset (reset=0 at an edge): state=IDLE, busy=0, ready=0, round_key=0, rcon=8'h01, i=0, all rk cleared to 0.
- Reset mid-expansion aborts immediately under the same rule; the next start restarts from scratch.
- Latency:
  - start sampled at edge E0 means rk[0] is valid after E0.
  - rk[i] is written at edge E0+i.
  - ready=1 and busy=0 are visible after E0+10, i.e. 10 cycles from start to ready.
- round_key latency is 1 cycle from round_sel.
- A round_sel change at edge E shows the new key after E+1. Back-to-back reads sustain one key per cycle.
- start and reset together: reset wins.

## Configuration
- KEYEXP_REVERSE_EN:
  - Defined: the read index is inverted, round_key <= rk[NR - round_sel], so round_sel=0 returns rk[10]. This lets the decryption round counter count up from 0. round_sel > NR still yields 0.
  - Undefined: direct indexing, round_key <= rk[round_sel].
  - Expansion behaviour and timing are identical either way.

## Test plan
- Reset: hold reset=0 for 2 cycles -> busy=0, ready=0, round_key=0; round_sel=5 still reads 0.
- FIPS-197 key: start with key=2b7e151628aed2a6abf7158809cf4f3c -> ready rises exactly 10 cycles after start. Then:
  - round_sel=0 -> same as key.
  - round_sel=1 -> a0fafe1788542cb123a339392a6c7605.
  - round_sel=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6. Under KEYEXP_REVERSE_EN this key is read at round_sel=0 instead.
- start pulsed at cycle 4 of expansion -> ignored; final rk[10] still d014f9a8c9ee2589e13f0cc8b6630ca6 and ready timing unchanged.
- reset=0 at cycle 5 of expansion -> busy=0, ready=0 and rk cleared next cycle. A new start then completes normally in 10 cycles.
- Re-key from READY with key=000102030405060708090a0b0c0d0e0f:
  - ready=0 the next cycle, ready=1 ten cycles after start.
  - rk[10] = 13111d7fe3944a17f307a78b4d2b30c5.
  - round_sel=11 and round_sel=15 both read 0.
